cart_rom_arbiter: RTL and testbench



---
 rtl/cart_rom_arbiter.sv | 170 +++++++++++++++++
 tb/tb_cart_rom_arbiter.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_rom_arbiter.sv
// Cartridge ROM port arbiter: buffers HPS download writes in a small FIFO and
// gives cartridge reads priority. Optional checksum enabled by CART_ROM_CHECKSUM_EN.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | after reset, no download seen yet
// LOAD   | download active, writes being accepted into the FIFO
// DRAIN  | download ended, FIFO and last RAM write still emptying
// READY  | ROM image complete in RAM, rom_loaded asserted
module cart_rom_arbiter #(
  parameter int ADDR_W      = 15,
  parameter int FIFO_DEPTH  = 4,
  parameter int WAIT_THRESH = 2
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [7:0]        cpu_data,
  output logic              cpu_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [ADDR_W:0]   rom_size,
  output logic              rom_loaded,
  output logic              overflow,
  output logic [7:0]        checksum
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_READY} state_t;

  state_t state_q, state_d;

  logic              dl_q;
  logic              dl_rise;
  logic              accept, push, drop, pop;
  logic              full, empty;
  logic [CNT_W-1:0]  count, count_next;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              wait_next;
  logic              rd_pend;
  logic [ADDR_W:0]   addr_plus1, size_base, size_next;
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [7:0]        fifo_data [FIFO_DEPTH];

  assign dl_rise    = ioctl_download & ~dl_q;
  assign accept     = ioctl_wr & ioctl_download & (ioctl_addr[24:ADDR_W] == '0);
  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign push       = accept & ~full;
  assign drop       = accept & full;
  assign pop        = ~cpu_req & ~empty;
  assign addr_plus1 = {1'b0, ioctl_addr[ADDR_W-1:0]} + (ADDR_W+1)'(1);
  assign rom_loaded = (state_q == S_READY);

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (pop && !push)
      count_next = count - 1'b1;
  end

  // Registered from the next count so the flag tracks occupancy with no extra lag.
  assign wait_next = (FIFO_DEPTH - int'(count_next)) <= WAIT_THRESH;

  always_comb begin
    size_base = dl_rise ? '0 : rom_size;
    size_next = size_base;
    if (push && (addr_plus1 > size_base))
      size_next = addr_plus1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (dl_rise) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_LOAD:  if (!ioctl_download)  state_d = S_DRAIN;
        S_DRAIN: if (empty && !mem_we) state_d = S_READY;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_addr[wr_ptr] <= ioctl_addr[ADDR_W-1:0];
      fifo_data[wr_ptr] <= ioctl_dout;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_q       <= 1'b0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ioctl_wait <= 1'b0;
      rd_pend    <= 1'b0;
      cpu_valid  <= 1'b0;
      cpu_data   <= '0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      rom_size   <= '0;
      overflow   <= 1'b0;
    end else begin
      dl_q       <= ioctl_download;
      count      <= count_next;
      ioctl_wait <= wait_next;
      rom_size   <= size_next;
      overflow   <= (overflow & ~dl_rise) | drop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      rd_pend   <= cpu_req;
      cpu_valid <= rd_pend;
      if (rd_pend)
        cpu_data <= mem_rdata;

      // Reads win the port; buffered writes only use otherwise idle cycles.
      if (cpu_req) begin
        mem_addr <= cpu_addr;
        mem_we   <= 1'b0;
      end else if (pop) begin
        mem_addr  <= fifo_addr[rd_ptr];
        mem_wdata <= fifo_data[rd_ptr];
        mem_we    <= 1'b1;
      end else begin
        mem_we <= 1'b0;
      end
    end
  end

`ifdef CART_ROM_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)
      csum_q <= '0;
    else if (dl_rise)
      csum_q <= push ? ioctl_dout : 8'd0;
    else if (push)
      csum_q <= csum_q + ioctl_dout;
  end

  assign checksum = csum_q;
`else
  assign checksum = 8'd0;
`endif

endmodule

// File: tb/tb_cart_rom_arbiter.sv
// Self-checking bench for cart_rom_arbiter: randomized download/read traffic
// against a occupancy/image model of the arbiter, plus directed corner cases.
module tb_cart_rom_arbiter;
  localparam int DEPTH  = 4;
  localparam int THRESH = 2;
  localparam int P_IDLE = 0, P_LOAD = 1, P_DRAIN = 2, P_READY = 3;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        dl, wr;
  logic [24:0] waddr;
  logic [7:0]  wdata;
  logic        ioctl_wait;
  logic        req;
  logic [14:0] raddr;
  logic [7:0]  cpu_data;
  logic        cpu_valid;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [15:0] rom_size;
  logic        rom_loaded;
  logic        overflow;
  logic [7:0]  checksum;

  always #5 clk_sys = ~clk_sys;

  cart_rom_arbiter dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(dl), .ioctl_wr(wr), .ioctl_addr(waddr), .ioctl_dout(wdata),
    .ioctl_wait(ioctl_wait),
    .cpu_req(req), .cpu_addr(raddr), .cpu_data(cpu_data), .cpu_valid(cpu_valid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rom_size(rom_size), .rom_loaded(rom_loaded), .overflow(overflow), .checksum(checksum)
  );

  // ROM block RAM: registered address from the DUT, data returned in that cycle.
  logic [7:0] ram [32768];
  bit ram_ready = 1'b0;
  always @(posedge clk_sys) begin
    if (!ram_ready) begin
      for (int i = 0; i < 32768; i++) ram[i] = 8'(i) ^ 8'h3C;
      ram_ready = 1'b1;
    end else if (mem_we) begin
      ram[mem_addr] = mem_wdata;
    end
  end
  assign mem_rdata = ram[mem_addr];

  int checks = 0;
  int errors = 0;

  // Reference model: expected RAM image, FIFO occupancy and status registers.
  logic [7:0] img [32768];
  int         m_cnt, m_phase, m_size;
  bit         m_ovf, m_dl_prev, m_inflight;
  logic [7:0] m_sum;
  int         rd_due[$];
  logic [7:0] rd_exp[$];
  int         cyc = 0;
  bit         wait_seen;
  int         valid_seen = 0;

  task automatic model_reset();
    m_cnt = 0; m_phase = P_IDLE; m_size = 0; m_ovf = 0; m_sum = 8'd0;
    m_dl_prev = 0; m_inflight = 0;
    rd_due.delete(); rd_exp.delete();
  endtask

  // Advance one clock, updating the model from the driven inputs, then check
  // the per-cycle outputs half a cycle after the edge.
  task automatic step();
    bit acc, rise, pop, exp_v, exp_w;
    acc  = wr && dl && (waddr[24:15] == 10'd0);
    rise = dl && !m_dl_prev;
    pop  = !req && (m_cnt > 0);
    if (rise) m_phase = P_LOAD;
    else if (m_phase == P_LOAD && !dl) m_phase = P_DRAIN;
    else if (m_phase == P_DRAIN && m_cnt == 0 && !m_inflight) m_phase = P_READY;
    if (rise) begin m_size = 0; m_ovf = 0; m_sum = 8'd0; end
    if (req) begin
      rd_due.push_back(cyc + 2);
      rd_exp.push_back(img[raddr]);
    end
    if (acc) begin
      if (m_cnt == DEPTH) begin
        m_ovf = 1;
      end else begin
        m_cnt++;
        if (int'(waddr[14:0]) + 1 > m_size) m_size = int'(waddr[14:0]) + 1;
        m_sum = m_sum + wdata;
        img[waddr[14:0]] = wdata;
      end
    end
    if (pop) m_cnt--;
    m_inflight = pop;
    m_dl_prev  = dl;

    @(posedge clk_sys);
    cyc++;
    @(negedge clk_sys);

    exp_w = (DEPTH - m_cnt) <= THRESH;
    if (ioctl_wait) wait_seen = 1;
    checks++;
    if (ioctl_wait !== exp_w) begin
      errors++;
      $display("FAIL ioctl_wait cyc=%0d: got %b expected %b", cyc, ioctl_wait, exp_w);
    end
    exp_v = (rd_due.size() > 0) && (rd_due[0] == cyc);
    checks++;
    if (cpu_valid !== exp_v) begin
      errors++;
      $display("FAIL cpu_valid cyc=%0d: got %b expected %b", cyc, cpu_valid, exp_v);
    end
    if (cpu_valid === 1'b1) valid_seen++;
    if (exp_v) begin
      checks++;
      if (cpu_data !== rd_exp[0]) begin
        errors++;
        $display("FAIL cpu_data cyc=%0d: got %h expected %h", cyc, cpu_data, rd_exp[0]);
      end
      void'(rd_due.pop_front());
      void'(rd_exp.pop_front());
    end
    while (rd_due.size() > 0 && rd_due[0] < cyc) begin
      void'(rd_due.pop_front());
      void'(rd_exp.pop_front());
    end
    checks++;
    if (rom_loaded !== (m_phase == P_READY)) begin
      errors++;
      $display("FAIL rom_loaded cyc=%0d: got %b expected %b", cyc, rom_loaded, m_phase == P_READY);
    end
    checks++;
    if (int'(rom_size) != m_size || overflow !== m_ovf) begin
      errors++;
      $display("FAIL status cyc=%0d: size %0d ovf %b expected size %0d ovf %b",
               cyc, rom_size, overflow, m_size, m_ovf);
    end
`ifdef CART_ROM_CHECKSUM_EN
    checks++;
    if (checksum !== m_sum) begin
      errors++;
      $display("FAIL checksum cyc=%0d: got %h expected %h", cyc, checksum, m_sum);
    end
`endif
  endtask

  task automatic write_byte(input logic [24:0] a, input logic [7:0] d);
    wr = 1'b1; waddr = a; wdata = d;
    step();
    wr = 1'b0;
  endtask

  task automatic wait_loaded(input int budget, output int used);
    used = 0;
    while (rom_loaded !== 1'b1 && used < budget) begin
      step();
      used++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; dl = 0; wr = 0; waddr = '0; wdata = '0; req = 0; raddr = '0;
    model_reset();
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    checks++;
    if ({cpu_data, cpu_valid, mem_addr, mem_we, mem_wdata, ioctl_wait,
         rom_size, rom_loaded, overflow, checksum} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: data %h v %b addr %h we %b wd %h wait %b size %0d ld %b ovf %b cs %h expected all 0",
               cpu_data, cpu_valid, mem_addr, mem_we, mem_wdata, ioctl_wait,
               rom_size, rom_loaded, overflow, checksum);
    end
    reset_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_load_no_reads();
    int used, bad;
    wait_seen = 0;
    dl = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      write_byte(25'(i), 8'($urandom));
      if ($urandom_range(0, 3) == 0) step();
    end
    dl = 1'b0;
    step();
    wait_loaded(3, used);
    checks++;
    if (rom_loaded !== 1'b1) begin
      errors++;
      $display("FAIL load_rom_loaded: got %b after %0d cycles, expected 1 within 3", rom_loaded, used);
    end
    checks++;
    if (rom_size !== 16'd4096 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL load_status: size %0d ovf %b expected 4096 0", rom_size, overflow);
    end
    checks++;
    if (wait_seen) begin
      errors++;
      $display("FAIL load_wait: ioctl_wait asserted=%b expected never", wait_seen);
    end
    bad = 0;
    for (int i = 0; i < 4096; i++) if (ram[i] !== img[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL load_ram: %0d bytes differ, expected 0", bad);
    end
  endtask

  task automatic test_starve();
    int next, t, used, bad;
    wait_seen = 0;
    dl = 1'b1;
    step();
    next = 0; t = 0;
    while ((next < 64 || t < 40) && t < 2000) begin
      req = (t >= 10 && t < 30);
      raddr = 15'h4000 | 15'($urandom_range(0, 16383));
      if (!ioctl_wait && next < 64) begin
        wr = 1'b1; waddr = 25'(next); wdata = 8'($urandom); next++;
      end else begin
        wr = 1'b0;
      end
      step();
      t++;
    end
    wr = 1'b0; req = 1'b0;
    checks++;
    if (next != 64) begin
      errors++;
      $display("FAIL starve_progress: sent %0d bytes expected 64", next);
    end
    dl = 1'b0;
    step();
    wait_loaded(10, used);
    checks++;
    if (rom_loaded !== 1'b1 || rom_size !== 16'd64 || overflow !== 1'b0 || !wait_seen) begin
      errors++;
      $display("FAIL starve_status: ld %b size %0d ovf %b wait_seen %b expected 1 64 0 1",
               rom_loaded, rom_size, overflow, wait_seen);
    end
    bad = 0;
    for (int i = 0; i < 64; i++) if (ram[i] !== img[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL starve_ram: %0d bytes differ, expected 0", bad);
    end
  endtask

  task automatic test_overflow();
    int used;
    dl = 1'b1; req = 1'b1;
    raddr = 15'h4000 | 15'($urandom_range(0, 16383));
    step();
    for (int i = 0; i < 6; i++) begin
      raddr = 15'h4000 | 15'($urandom_range(0, 16383));
      write_byte(25'(i), 8'($urandom));
    end
    repeat (3) begin
      raddr = 15'h4000 | 15'($urandom_range(0, 16383));
      step();
    end
    checks++;
    if (overflow !== 1'b1 || rom_size !== 16'd4 || ioctl_wait !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: ovf %b size %0d wait %b expected 1 4 1", overflow, rom_size, ioctl_wait);
    end
    req = 1'b0; dl = 1'b0;
    step();
    wait_loaded(12, used);
    checks++;
    if (overflow !== 1'b1 || rom_loaded !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: ovf %b ld %b expected 1 1", overflow, rom_loaded);
    end
    dl = 1'b1;
    step();
    checks++;
    if (overflow !== 1'b0 || rom_size !== 16'd0 || rom_loaded !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: ovf %b size %0d ld %b expected 0 0 0", overflow, rom_size, rom_loaded);
    end
    dl = 1'b0;
    step();
    wait_loaded(6, used);
  endtask

  task automatic test_out_of_range();
    int used;
    dl = 1'b1;
    step();
    write_byte(25'h40, 8'($urandom));
    write_byte(25'h8000, ~img[0]);
    write_byte(25'h1_0001, ~img[1]);
    dl = 1'b0;
    step();
    wait_loaded(6, used);
    checks++;
    if (rom_size !== 16'h41 || ram[0] !== img[0] || ram[1] !== img[1] || ram[16'h40] !== img[16'h40]) begin
      errors++;
      $display("FAIL out_of_range: size %0h ram0 %h ram1 %h expected size 41 ram0 %h ram1 %h",
               rom_size, ram[0], ram[1], img[0], img[1]);
    end
  endtask

  task automatic test_fall_with_write();
    int used;
    logic [7:0] old100;
    old100 = img[100];
    dl = 1'b1;
    step();
    write_byte(25'd5, 8'($urandom));
    dl = 1'b0;
    write_byte(25'd100, ~old100);
    wait_loaded(6, used);
    checks++;
    if (rom_size !== 16'd6 || ram[100] !== old100 || ram[5] !== img[5]) begin
      errors++;
      $display("FAIL fall_with_write: size %0d ram100 %h expected 6 %h", rom_size, ram[100], old100);
    end
  endtask

  task automatic test_checksum();
    int used;
    dl = 1'b1;
    step();
    write_byte(25'h200, 8'hFF);
    write_byte(25'h201, 8'h02);
    write_byte(25'h202, 8'h10);
    dl = 1'b0;
    step();
    wait_loaded(6, used);
    checks++;
`ifdef CART_ROM_CHECKSUM_EN
    if (checksum !== 8'h11 || rom_size !== 16'h203) begin
      errors++;
      $display("FAIL checksum_load: cs %h size %0h expected 11 203", checksum, rom_size);
    end
`else
    if (checksum !== 8'h00 || rom_size !== 16'h203) begin
      errors++;
      $display("FAIL checksum_load: cs %h size %0h expected 00 203", checksum, rom_size);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = valid_seen;
    for (int i = 0; i < 16; i++) begin
      req = 1'b1;
      raddr = 15'($urandom_range(0, 32767));
      step();
    end
    req = 1'b0;
    repeat (3) step();
    checks++;
    if (valid_seen - v0 != 16) begin
      errors++;
      $display("FAIL back_to_back: got %0d valids expected 16", valid_seen - v0);
    end
  endtask

  task automatic test_read_reset();
    int used, bad;
    dl = 1'b1;
    step();
    write_byte(25'h123, 8'hA5);
    dl = 1'b0;
    step();
    wait_loaded(6, used);
    req = 1'b1; raddr = 15'h123;
    step();
    req = 1'b0;
    step();
    checks++;
    if (cpu_valid !== 1'b1 || cpu_data !== 8'hA5) begin
      errors++;
      $display("FAIL read_a5: valid %b data %h expected 1 a5", cpu_valid, cpu_data);
    end
    req = 1'b1; raddr = 15'h123;
    step();
    req = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({cpu_data, cpu_valid, mem_addr, mem_we, mem_wdata, ioctl_wait,
         rom_size, rom_loaded, overflow, checksum} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: data %h v %b addr %h we %b size %0d ld %b expected all 0",
               cpu_data, cpu_valid, mem_addr, mem_we, rom_size, rom_loaded);
    end
    model_reset();
    @(posedge clk_sys);
    @(negedge clk_sys);
    checks++;
    if (cpu_valid !== 1'b0 || cpu_data !== 8'h00) begin
      errors++;
      $display("FAIL midreset_read: valid %b data %h expected 0 00", cpu_valid, cpu_data);
    end
    reset_n = 1'b1;
    repeat (2) step();
    bad = 0;
    for (int i = 0; i < 32768; i++) if (ram[i] !== img[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL final_ram: %0d bytes differ, expected 0", bad);
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) img[i] = 8'(i) ^ 8'h3C;
    test_reset();
    test_load_no_reads();
    test_starve();
    test_overflow();
    test_out_of_range();
    test_fall_with_write();
    test_checksum();
    test_back_to_back();
    test_read_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
